// File: rtl/instr_expand_queue_pkg.sv
// Shared types for the instruction expand queue.
// - instruction type codes (ARITHMETIC / RAM / LOAD_STORE / RESERVED)
// - per-type payload widths and the stored entry layout at the default widths
// - select_payload(): picks the payload for a type and zero-extends it
package instr_expand_queue_pkg;

  localparam int ARITH_INSTR_W = 10;
  localparam int RAM_INSTR_W   = 9;
  localparam int LD_ST_INSTR_W = 10;
  localparam int PAYLOAD_MAX_W = 10;

  localparam int IQ_ADDR_W    = 18;
  localparam int IQ_LOG_SS_W  = 4;
  localparam int IQ_PAYLOAD_W = 10;

  typedef enum logic [1:0] {
    INSTR_TYPE_ARITHMETIC = 2'd0,
    INSTR_TYPE_RAM        = 2'd1,
    INSTR_TYPE_LOAD_STORE = 2'd2,
    INSTR_TYPE_RESERVED   = 2'd3
  } instr_type_e;

  // Entry layout at the default widths; the top mirrors this field order
  // with its own parameter widths.
  typedef struct packed {
    instr_type_e              itype;
    logic [IQ_PAYLOAD_W-1:0]  payload;
    logic [IQ_LOG_SS_W-1:0]   copy_count;
    logic [IQ_ADDR_W-1:0]     cache_addr;
    logic [IQ_ADDR_W-1:0]     main_mem_addr;
    logic [IQ_ADDR_W-1:0]     d_cache_addr;
    logic [IQ_ADDR_W-1:0]     d_main_mem_addr;
  } iq_entry_t;

  function automatic logic [PAYLOAD_MAX_W-1:0] select_payload(
    input instr_type_e              t,
    input logic [ARITH_INSTR_W-1:0] a,
    input logic [RAM_INSTR_W-1:0]   r,
    input logic [LD_ST_INSTR_W-1:0] l
  );
    logic [PAYLOAD_MAX_W-1:0] p;
    p = '0;
    case (t)
      INSTR_TYPE_ARITHMETIC: p = a;
      INSTR_TYPE_RAM:        p = PAYLOAD_MAX_W'(r);
      INSTR_TYPE_LOAD_STORE: p = l;
      default:               p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/instr_expand_queue_if.sv
// Producer/consumer bus of the instruction expand queue.
// slave  : queue side (enqueue fields and re in; status and micro-instruction out)
// master : control unit / dispatch side
interface iq_if #(
  parameter int ADDR_W    = 18,
  parameter int CNT_W     = 4,
  parameter int PAYLOAD_W = 10
);
  import instr_expand_queue_pkg::*;

  // enqueue side
  logic                     we;
  logic                     full;
  logic [1:0]               in_instr_type;
  logic [CNT_W-1:0]         copy_count;
  logic [ADDR_W-1:0]        cache_addr;
  logic [ADDR_W-1:0]        main_mem_addr;
  logic [ADDR_W-1:0]        d_cache_addr;
  logic [ADDR_W-1:0]        d_main_mem_addr;
  logic [ARITH_INSTR_W-1:0] in_arith_instr;
  logic [RAM_INSTR_W-1:0]   in_ram_instr;
  logic [LD_ST_INSTR_W-1:0] in_ld_st_instr;

  // dispatch side
  logic                     out_valid;
  logic                     re;
  logic [1:0]               out_instr_type;
  logic [PAYLOAD_W-1:0]     out_payload;
  logic [ADDR_W-1:0]        out_cache_addr;
  logic [ADDR_W-1:0]        out_main_mem_addr;
  logic                     out_last;
  logic                     empty;

  modport slave (
    input  we, in_instr_type, copy_count, cache_addr, main_mem_addr,
           d_cache_addr, d_main_mem_addr, in_arith_instr, in_ram_instr,
           in_ld_st_instr, re,
    output full, out_valid, out_instr_type, out_payload, out_cache_addr,
           out_main_mem_addr, out_last, empty
  );

  modport master (
    output we, in_instr_type, copy_count, cache_addr, main_mem_addr,
           d_cache_addr, d_main_mem_addr, in_arith_instr, in_ram_instr,
           in_ld_st_instr, re,
    input  full, out_valid, out_instr_type, out_payload, out_cache_addr,
           out_main_mem_addr, out_last, empty
  );
endinterface

// File: rtl/instr_expand_queue_entry_ram.sv
// Entry storage for the expand queue: DEPTH x WIDTH, synchronous write,
// asynchronous read. Not reset; validity is tracked by the pointers.
// clk   : write clock
// we    : write enable, waddr/wdata : write port
// raddr : read address, rdata : combinational read data
module iq_entry_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_expand_queue.sv
// Instruction expand queue: circular FIFO of compressed entries; the head
// entry is replayed copy_count+1 times with stride-advanced cache and
// main-memory addresses over a valid/ready handshake.
// clk   : rising-edge clock
// reset : asynchronous, active-low
// bus   : iq_if.slave (enqueue fields, full, out_* micro-instruction, re, empty)
// flush : only when IQ_FLUSH_EN is defined; clears the queue, beats any
//         same-cycle enqueue or handshake
module instr_expand_queue
  import instr_expand_queue_pkg::*;
#(
  parameter int DEPTH                 = 8,
  parameter int LOG_SUPERSCALAR_WIDTH = IQ_LOG_SS_W,
  parameter int ADDR_W                = IQ_ADDR_W,
  parameter int PAYLOAD_W             = IQ_PAYLOAD_W
) (
  input logic clk,
  input logic reset,
  iq_if.slave bus
`ifdef IQ_FLUSH_EN
  ,
  input logic flush
`endif
);
  localparam int PTR_W = $clog2(DEPTH);

  // Same field order as iq_entry_t, sized by this instance's parameters.
  typedef struct packed {
    instr_type_e                      itype;
    logic [PAYLOAD_W-1:0]             payload;
    logic [LOG_SUPERSCALAR_WIDTH-1:0] copy_count;
    logic [ADDR_W-1:0]                cache_addr;
    logic [ADDR_W-1:0]                main_mem_addr;
    logic [ADDR_W-1:0]                d_cache_addr;
    logic [ADDR_W-1:0]                d_main_mem_addr;
  } entry_t;

  logic [PTR_W-1:0]                 wr_ptr, rd_ptr;
  logic [PTR_W:0]                   count, count_nxt;
  logic [LOG_SUPERSCALAR_WIDTH-1:0] k;
  logic [ADDR_W-1:0]                off_cache, off_mem;
  logic                             full_q;
  logic                             flush_i;
  logic                             valid, push, step, last_copy, pop;
  entry_t                           wr_entry, head;

`ifdef IQ_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign wr_entry.itype           = instr_type_e'(bus.in_instr_type);
  assign wr_entry.payload         = PAYLOAD_W'(select_payload(
                                      instr_type_e'(bus.in_instr_type),
                                      bus.in_arith_instr, bus.in_ram_instr,
                                      bus.in_ld_st_instr));
  assign wr_entry.copy_count      = bus.copy_count;
  assign wr_entry.cache_addr      = bus.cache_addr;
  assign wr_entry.main_mem_addr   = bus.main_mem_addr;
  assign wr_entry.d_cache_addr    = bus.d_cache_addr;
  assign wr_entry.d_main_mem_addr = bus.d_main_mem_addr;

  // full is the registered status, so a same-cycle pop cannot admit a write.
  assign push      = bus.we && !full_q && !flush_i &&
                     (bus.in_instr_type != INSTR_TYPE_RESERVED);
  assign valid     = (count != '0);
  assign step      = valid && bus.re;
  assign last_copy = (k == head.copy_count);
  assign pop       = step && last_copy;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  iq_entry_ram #(.DEPTH(DEPTH), .WIDTH($bits(entry_t))) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // off_* hold k*stride as running sums; they return to 0 on a pop so the
  // next head starts at its own base address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full_q    <= 1'b0;
      k         <= '0;
      off_cache <= '0;
      off_mem   <= '0;
    end else if (flush_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full_q    <= 1'b0;
      k         <= '0;
      off_cache <= '0;
      off_mem   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nxt;
      full_q <= (count_nxt == (PTR_W+1)'(DEPTH));
      if (step) begin
        if (last_copy) begin
          k         <= '0;
          off_cache <= '0;
          off_mem   <= '0;
        end else begin
          k         <= k + 1'b1;
          off_cache <= off_cache + head.d_cache_addr;
          off_mem   <= off_mem + head.d_main_mem_addr;
        end
      end
    end
  end

  // Data outputs are forced to 0 while empty so stale RAM never leaks out.
  assign bus.out_valid         = valid;
  assign bus.empty             = !valid;
  assign bus.full              = full_q;
  assign bus.out_last          = valid && last_copy;
  assign bus.out_instr_type    = valid ? head.itype : 2'b00;
  assign bus.out_payload       = valid ? head.payload : '0;
  assign bus.out_cache_addr    = valid ? head.cache_addr + off_cache : '0;
  assign bus.out_main_mem_addr = valid ? head.main_mem_addr + off_mem : '0;

endmodule

// File: tb/tb_instr_expand_queue.sv
// Bench for instr_expand_queue: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a queue-based model.
module tb_instr_expand_queue;
  localparam int DEPTH = 8;

  logic clk, reset;
  logic flush;
  iq_if #(.ADDR_W(18), .CNT_W(4), .PAYLOAD_W(10)) bus ();

  instr_expand_queue #(.DEPTH(DEPTH), .LOG_SUPERSCALAR_WIDTH(4),
                       .ADDR_W(18), .PAYLOAD_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IQ_FLUSH_EN
    ,
    .flush (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit [1:0]  t;
    bit [9:0]  pay;
    int        cc;
    bit [17:0] ca, ma, dca, dma;
  } ment_t;

  ment_t mq[$];
  int    mk = 0;
  ment_t ne;
  int    msz;
  bit    mflush;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      mk = 0;
    end else begin
      msz = mq.size();
      mflush = 0;
`ifdef IQ_FLUSH_EN
      mflush = flush;
`endif
      ne.t   = bus.in_instr_type;
      ne.pay = (bus.in_instr_type == 2'd0) ? bus.in_arith_instr :
               (bus.in_instr_type == 2'd1) ? {1'b0, bus.in_ram_instr} :
                                             bus.in_ld_st_instr;
      ne.cc  = int'(bus.copy_count);
      ne.ca  = bus.cache_addr;     ne.ma  = bus.main_mem_addr;
      ne.dca = bus.d_cache_addr;   ne.dma = bus.d_main_mem_addr;
      if (mflush) begin
        mq.delete();
        mk = 0;
      end else begin
        if (msz > 0 && bus.re) begin
          if (mk == mq[0].cc) begin
            void'(mq.pop_front());
            mk = 0;
          end else mk++;
        end
        if (bus.we && msz != DEPTH && bus.in_instr_type != 2'd3)
          mq.push_back(ne);
      end
    end
  end

  function automatic logic [17:0] model_addr(input bit [17:0] base, input bit [17:0] d);
    longint s;
    s = longint'(base) + longint'(mk) * longint'(d);
    return s[17:0];
  endfunction

  function automatic logic [17:0] model_cache();
    if (mq.size() == 0) return 18'h0;
    return model_addr(mq[0].ca, mq[0].dca);
  endfunction

  // ---------------- per-cycle compare ----------------
  ment_t ch;
  bit    ev;
  always @(negedge clk) if (chk_en) begin
    ev = (mq.size() > 0);
    chk("valid", bus.out_valid, ev);
    chk("empty", bus.empty, !ev);
    chk("full", bus.full, mq.size() == DEPTH);
    if (ev) begin
      ch = mq[0];
      chk("type", bus.out_instr_type, ch.t);
      chk("payload", bus.out_payload, ch.pay);
      chk("cache_addr", bus.out_cache_addr, model_addr(ch.ca, ch.dca));
      chk("mem_addr", bus.out_main_mem_addr, model_addr(ch.ma, ch.dma));
      chk("last", bus.out_last, mk == ch.cc);
    end else begin
      chk("type_idle", bus.out_instr_type, 0);
      chk("payload_idle", bus.out_payload, 0);
      chk("cache_idle", bus.out_cache_addr, 0);
      chk("mem_idle", bus.out_main_mem_addr, 0);
      chk("last_idle", bus.out_last, 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.we = 0; bus.re = 0; bus.in_instr_type = 0; bus.copy_count = 0;
    bus.cache_addr = 0; bus.main_mem_addr = 0;
    bus.d_cache_addr = 0; bus.d_main_mem_addr = 0;
    bus.in_arith_instr = 0; bus.in_ram_instr = 0; bus.in_ld_st_instr = 0;
    flush = 0;
  endtask

  // Unselected payload inputs get noise so the type mux is exercised.
  task automatic load(input bit [1:0] t, input bit [9:0] pay, input bit [3:0] cc,
                      input bit [17:0] ca, input bit [17:0] dca,
                      input bit [17:0] ma, input bit [17:0] dma);
    bus.in_instr_type = t; bus.copy_count = cc;
    bus.cache_addr = ca; bus.d_cache_addr = dca;
    bus.main_mem_addr = ma; bus.d_main_mem_addr = dma;
    bus.in_arith_instr = (t == 0) ? pay      : 10'($urandom);
    bus.in_ram_instr   = (t == 1) ? pay[8:0] : 9'($urandom);
    bus.in_ld_st_instr = (t == 2) ? pay      : 10'($urandom);
  endtask

  bit [17:0] wrap_exp [4] = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
  bit [9:0]  got[$];
  bit [4:0]  pat;
  int        xfers;

  initial begin
    idle_in();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 chk_en = 1;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // reset / idle
    chk("rst_empty", bus.empty, 1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_payload", bus.out_payload, 0);
    bus.re = 1;
    repeat (3) step();
    chk("idle_empty", bus.empty, 1);
    chk("idle_valid", bus.out_valid, 0);

    // 16-copy expansion
    load(0, 10'h200, 4'd15, 18'h10, 18'd4, 18'h100, 18'h20);
    bus.we = 1; bus.re = 1;
    step();
    bus.we = 0;
    for (int i = 0; i < 16; i++) begin
      chk("exp16_valid", bus.out_valid, 1);
      chk("exp16_payload", bus.out_payload, 10'h200);
      chk("exp16_addr", bus.out_cache_addr, 18'h10 + 4 * i);
      chk("exp16_model_addr", model_cache(), 18'h10 + 4 * i);
      chk("exp16_mem", bus.out_main_mem_addr, 18'h100 + 18'h20 * i);
      chk("exp16_last", bus.out_last, i == 15);
      step();
    end
    chk("exp16_empty", bus.empty, 1);

    // address wrap, RAM-type payload zero-extension
    load(1, 10'h155, 4'd3, 18'h3FFFE, 18'd1, 18'h0, 18'h0);
    bus.we = 1;
    step();
    bus.we = 0;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_addr", bus.out_cache_addr, wrap_exp[i]);
      chk("wrap_model_addr", model_cache(), wrap_exp[i]);
      chk("wrap_payload", bus.out_payload, 10'h155);
      chk("wrap_type", bus.out_instr_type, 1);
      step();
    end
    chk("wrap_empty", bus.empty, 1);

    // fill to full, drop 9th, drain with concurrent push
    bus.re = 0;
    for (int i = 0; i < DEPTH; i++) begin
      load(2, 10'(i), 4'd0, 18'(i), 18'd0, 18'(i), 18'd0);
      bus.we = 1;
      step();
    end
    chk("fill_full", bus.full, 1);
    load(2, 10'h099, 4'd0, 18'h0, 18'd0, 18'h0, 18'd0);
    step();
    chk("fill_full_9th", bus.full, 1);
    load(2, 10'h3AA, 4'd0, 18'h0, 18'd0, 18'h0, 18'd0);
    bus.re = 1;
    got.delete();
    for (int c = 0; c < 30 && got.size() < 9; c++) begin
      if (c == 1) chk("drain_full_clear", bus.full, 0);
      if (bus.out_valid) got.push_back(bus.out_payload);
      step();
      if (c == 1) bus.we = 0;
    end
    bus.we = 0;
    chk("drain_count", got.size(), 9);
    for (int i = 0; i < 9 && i < got.size(); i++)
      chk("drain_order", got[i], (i < 8) ? i : 10'h3AA);
    repeat (2) step();
    chk("drain_empty", bus.empty, 1);

    // backpressure
    load(0, 10'h1C3, 4'd2, 18'h40, 18'd8, 18'h0, 18'd1);
    bus.we = 1; bus.re = 0;
    step();
    bus.we = 0;
    pat = 5'b10101;
    xfers = 0;
    for (int i = 0; i < 5; i++) begin
      bus.re = pat[i];
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_payload", bus.out_payload, 10'h1C3);
      chk("bp_addr", bus.out_cache_addr, 18'h40 + 8 * xfers);
      if (bus.out_valid && bus.re) xfers++;
      step();
    end
    chk("bp_xfers", xfers, 3);
    chk("bp_empty", bus.empty, 1);

    // reserved type dropped
    load(3, 10'h3FF, 4'd0, 18'h1, 18'd1, 18'h1, 18'd1);
    bus.we = 1; bus.re = 0;
    step();
    bus.we = 0;
    chk("rsvd_empty", bus.empty, 1);
    step();
    chk("rsvd_empty2", bus.empty, 1);

    // async reset mid-expansion at k=5
    load(0, 10'h0AB, 4'd9, 18'h100, 18'd2, 18'h0, 18'd3);
    bus.we = 1; bus.re = 1;
    step();
    bus.we = 0;
    repeat (5) step();
    chk("mid_addr_k5", bus.out_cache_addr, 18'h10A);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_empty", bus.empty, 1);
    @(negedge clk);
    reset = 1'b1;
    bus.re = 0;
    step();
    chk("mid_post_empty", bus.empty, 1);

`ifdef IQ_FLUSH_EN
    for (int i = 0; i < 3; i++) begin
      load(0, 10'(i + 5), 4'd1, 18'h0, 18'd1, 18'h0, 18'd1);
      bus.we = 1;
      step();
    end
    chk("flush_pre_empty", bus.empty, 0);
    load(0, 10'h111, 4'd0, 18'h0, 18'd0, 18'h0, 18'd0);
    flush = 1;
    step();
    flush = 0; bus.we = 0;
    chk("flush_empty", bus.empty, 1);
    step();
    chk("flush_no_store", bus.empty, 1);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      load(2'($urandom), 10'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2)),
           18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
      bus.we = ($urandom_range(0, 1) == 1);
      bus.re = ($urandom_range(0, 9) < 6);
`ifdef IQ_FLUSH_EN
      flush = ($urandom_range(0, 99) == 0);
`endif
      step();
    end
    idle_in();
    step();

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_expand_queue.md
Name: instr_expand_queue

Overview:
- Parametrised successor to the single-issue instruction queue.
- Buffers compressed instruction entries (type, payload, copy count, base addresses, strides) in a circular FIFO.
- Expands each entry at the head into copy_count+1 micro-instructions with stride-advanced cache and main-memory addresses.
- Sits between the control unit (producer) and the DMA/math/cache-regfile dispatch (consumer), with a valid/ready output handshake.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥2.
- LOG_SUPERSCALAR_WIDTH, 4, width of copy_count; an entry expands to at most 2^LOG_SUPERSCALAR_WIDTH copies.
- ADDR_W, 18, width of cache and main-memory addresses and strides.
- PAYLOAD_W, 10, width of the stored instruction payload.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- we  in  1  enqueue request.
- full  out  1  queue full; we is ignored while high.
- in_instr_type  in  2  0=ARITHMETIC, 1=RAM, 2=LOAD_STORE, 3=reserved.
- copy_count  in  LOG_SUPERSCALAR_WIDTH  number of copies minus 1.
- cache_addr, main_mem_addr  in  ADDR_W  base addresses.
- d_cache_addr, d_main_mem_addr  in  ADDR_W  per-copy strides.
- in_arith_instr  in  10  arithmetic payload.
- in_ram_instr  in  9  RAM payload.
- in_ld_st_instr  in  10  load/store payload.
- out_valid  out  1  micro-instruction available.
- re  in  1  consumer ready.
- out_instr_type  out  2  type of the current micro-instruction.
- out_payload  out  PAYLOAD_W  payload selected by type, zero-extended.
- out_cache_addr, out_main_mem_addr  out  ADDR_W  addresses of the current copy.
- out_last  out  1  current copy is the final copy of its entry.
- empty  out  1  no stored entries.

Behaviour:
- Reset (reset=0, async): wr_ptr, rd_ptr and count clear to 0; copy index k clears to 0. Outputs: empty=1, full=0, out_valid=0, out_last=0; all data outputs 0.
- Enqueue: on a rising edge with we=1 and full=0, the payload is selected by in_instr_type and stored together with all address fields.
  - Type 3 is dropped silently: nothing is stored and the pointer does not advance.
- full = (count==DEPTH), registered. A pop in the same cycle does not unblock a write; a write that arrives while full is lost.
- Output timing:
  - out_valid = !empty, driven combinationally from the head entry.
  - First-word latency is 1 cycle: an entry written at edge N is visible after edge N.
- Address generation, using copy index k of the head entry:
  - out_cache_addr = cache_addr + k*d_cache_addr, modulo 2^ADDR_W (wrap-around, no saturation).
  - out_main_mem_addr is computed the same way from main_mem_addr and d_main_mem_addr.
  - Implemented with running-sum registers, not a multiplier. The running sums reload from the new head on a pop.
- Handshake: a transfer happens on an edge where out_valid && re.
  - If k < copy_count: k increments.
  - If k == copy_count: k returns to 0 and the entry is popped.
- out_last = out_valid && (k == copy_count).
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
- Push into an empty queue while re=1: no bypass; the entry is emitted on the following cycle.
- Pointers wrap modulo DEPTH.
- Reset mid-expansion discards the partial entry and all stored entries.
- Payloads and strides are held per entry. Changing inputs after enqueue has no effect.

Optional Feature:
- Macro: IQ_FLUSH_EN.
- Defined: adds input port flush (1 bit). When flush=1 at an edge:
  - count, pointers and k clear, so empty=1 next cycle.
  - A simultaneous we is discarded.
  - flush takes priority over any handshake in the same cycle.
- Undefined: no flush port; the queue empties only through normal consumption or reset.

Decomposition:
- Shared types package holds:
  - INSTR_TYPE_ARITHMETIC / RAM / LOAD_STORE / RESERVED constants;
  - the iq_entry_t packed struct (type, payload, copy_count, four address fields);
  - the payload width constants (10, 9, 10).
- Sub-module iq_entry_ram: DEPTH×$bits(iq_entry_t) storage with synchronous write and asynchronous read.
- Pointers, count, expander and address sums stay in the top level.

Test Plan:
- Reset then idle: empty=1, out_valid=0, out_payload=0; re=1 for 3 cycles leaves state unchanged.
- Enqueue ARITHMETIC, payload 10'h200, copy_count=15, cache_addr=0x10, d_cache_addr=4, with re=1 throughout:
  - expect 16 transfers with out_cache_addr 0x10, 0x14, … 0x4C;
  - out_last only on the 16th transfer; then empty=1.
- Wrap: cache_addr=0x3FFFE, d_cache_addr=1, copy_count=3 -> addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- Fill to DEPTH=8 with re=0 -> full=1; a 9th we is dropped.
  - Drain with re=1 -> the 8 entries appear in order.
  - A concurrent push on the draining cycle is accepted once full=0.
- Backpressure: copy_count=2, re toggled 1,0,1,0,1 -> k advances only on re=1 edges; exactly 3 transfers and out_payload stable.
- Type 3 write -> empty stays 1. Reset asserted mid-expansion at k=5 -> out_valid=0 immediately (async), and the queue is empty after release.
- With IQ_FLUSH_EN: 3 entries queued, flush=1 with we=1 -> empty=1 next cycle and no entry is stored.
